// File: rtl/icb2apb_nbridge_if.sv
// Bundled ICB command/response and N-port APB4 signals for icb2apb_nbridge.
// The slave modport is the bridge's view; master is the surrounding system's view.
interface icb2apb_nbridge_if #(
  parameter int N_APB = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic                  icb_cmd_valid;
  logic                  icb_cmd_ready;
  logic [AW-1:0]         icb_cmd_addr;
  logic                  icb_cmd_read;
  logic [DW-1:0]         icb_cmd_wdata;
  logic [DW/8-1:0]       icb_cmd_wmask;
  logic                  icb_rsp_valid;
  logic                  icb_rsp_ready;
  logic [DW-1:0]         icb_rsp_rdata;
  logic                  icb_rsp_err;

  logic [AW-1:0]         apb_paddr;
  logic                  apb_pwrite;
  logic [DW-1:0]         apb_pwdata;
  logic [DW/8-1:0]       apb_pstrb;
  logic [N_APB-1:0]      apb_psel;
  logic                  apb_penable;
  logic [N_APB*DW-1:0]   apb_prdata;
  logic [N_APB-1:0]      apb_pready;
  logic [N_APB-1:0]      apb_pslverr;

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_cmd_ready,
    output icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
    input  icb_rsp_ready,
    output apb_paddr, apb_pwrite, apb_pwdata, apb_pstrb, apb_psel, apb_penable,
    input  apb_prdata, apb_pready, apb_pslverr
  );

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_cmd_ready,
    input  icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
    output icb_rsp_ready,
    input  apb_paddr, apb_pwrite, apb_pwdata, apb_pstrb, apb_psel, apb_penable,
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/icb2apb_nbridge.sv
// ICB slave to N-port APB4 master bridge: one APB transfer per ICB command, misses answer with err.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module icb2apb_nbridge #(
  parameter int             N_APB       = 4,
  parameter int             AW          = 32,
  parameter int             DW          = 32,
  parameter int             REGION_BITS = 12,
  parameter logic [AW-1:0]  BASE_ADDR   = AW'(32'h1000_0000),
  parameter int             TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  icb2apb_nbridge_if.slave      bus
);
  localparam int CW     = (N_APB > 1) ? $clog2(N_APB) : 1;
  localparam int HI_LSB = REGION_BITS + CW;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3} state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [N_APB-1:0]    psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [AW-1:0]       paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DW-1:0]       pwdata_q, pwdata_d;
  logic [DW/8-1:0]     pstrb_q, pstrb_d;

  logic [CW-1:0]       cmd_idx;
  logic                cmd_hit;
  logic [N_APB-1:0]    cmd_onehot;
  logic                sel_ready;
  logic                sel_slverr;
  logic [DW-1:0]       sel_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`endif

  assign cmd_idx = bus.icb_cmd_addr[REGION_BITS +: CW];
  assign cmd_hit = (bus.icb_cmd_addr[AW-1:HI_LSB] == BASE_ADDR[AW-1:HI_LSB]) &&
                   (32'(cmd_idx) < 32'(N_APB));

  // Port decode and response mux; psel_q is one-hot in ACCESS, so it doubles as the latched index.
  always_comb begin
    cmd_onehot = '0;
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < N_APB; k++) begin
      cmd_onehot[k] = (cmd_idx == CW'(k));
      sel_ready     = sel_ready  | (psel_q[k] & bus.apb_pready[k]);
      sel_slverr    = sel_slverr | (psel_q[k] & bus.apb_pslverr[k]);
      sel_rdata     = sel_rdata  | (bus.apb_prdata[k*DW +: DW] & {DW{psel_q[k]}});
    end
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    psel_d    = '0;
    penable_d = 1'b0;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
`ifdef APB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.icb_cmd_valid && cmd_hit) begin
          state_d  = S_SETUP;
          psel_d   = cmd_onehot;
          paddr_d  = bus.icb_cmd_addr;
          pwrite_d = !bus.icb_cmd_read;
          pwdata_d = bus.icb_cmd_wdata;
          pstrb_d  = bus.icb_cmd_read ? '0 : bus.icb_cmd_wmask;
        end else if (bus.icb_cmd_valid) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = psel_q;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
      end
      S_ACCESS: begin
        if (sel_ready) begin
          state_d = S_RESP;
          rdata_d = pwrite_q ? '0 : sel_rdata;
          err_d   = sel_slverr;
`ifdef APB_TIMEOUT_EN
        // The count reaching the limit this cycle abandons the transfer.
        end else if ((to_cnt_q + TO_W'(1)) == TO_W'(TIMEOUT_CYC)) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          psel_d    = psel_q;
          penable_d = 1'b1;
          to_cnt_d  = to_cnt_q + TO_W'(1);
        end
`else
        end else begin
          psel_d    = psel_q;
          penable_d = 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (bus.icb_rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
`ifdef APB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign bus.icb_cmd_ready = cmd_ready_q;
  assign bus.icb_rsp_valid = rsp_valid_q;
  assign bus.icb_rsp_rdata = rdata_q;
  assign bus.icb_rsp_err   = err_q;
  assign bus.apb_psel      = psel_q;
  assign bus.apb_penable   = penable_q;
  assign bus.apb_paddr     = paddr_q;
  assign bus.apb_pwrite    = pwrite_q;
  assign bus.apb_pwdata    = pwdata_q;
  assign bus.apb_pstrb     = pstrb_q;

endmodule

// File: tb/tb_icb2apb_nbridge.sv
// Self-checking bench for icb2apb_nbridge: directed cases plus randomized commands against a
// transaction-level model of address decode, APB phase timing and response contents.
module tb_icb2apb_nbridge;
  localparam int          N_APB  = 4;
  localparam int          TO_CYC = 8;
  localparam logic [31:0] BASE   = 32'h1000_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  icb2apb_nbridge_if #(.N_APB(N_APB), .AW(32), .DW(32)) bus ();

  icb2apb_nbridge #(
    .N_APB(N_APB), .AW(32), .DW(32), .REGION_BITS(12),
    .BASE_ADDR(BASE), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: 16 KiB block at BASE split into four 4 KiB port windows.
  function automatic bit model_hit(input logic [31:0] a);
    return (a >> 14) == (BASE >> 14);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a >> 12) & 32'd3);
  endfunction

  task automatic drive_noise(input int tgt);
    for (int k = 0; k < N_APB; k++) begin
      if (k != tgt) begin
        bus.apb_pready[k]          = 1'($urandom);
        bus.apb_pslverr[k]         = 1'($urandom);
        bus.apb_prdata[k*32 +: 32] = $urandom;
      end
    end
  endtask

  // One full ICB transaction; the APB slave on the target port inserts 'waits' wait states
  // (or never answers when 'hang' is set), and the response is held off for 'bp' cycles.
  task automatic run_txn(input logic [31:0] addr, input bit rd, input logic [31:0] wdata,
                         input logic [3:0] wmask, input int waits, input logic [31:0] prd,
                         input bit slverr, input int bp, input bit hang);
    bit          hit;
    int          idx;
    int          n_acc;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    bit          exp_err;
    hit     = model_hit(addr);
    idx     = model_idx(addr);
    exp_sel = hit ? (4'b0001 << idx) : 4'b0000;
    @(negedge clk);
    check("cmd_ready_idle", bus.icb_cmd_ready, 1);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = addr;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_wdata = wdata;
    bus.icb_cmd_wmask = wmask;
    bus.icb_rsp_ready = 1'b0;
    drive_noise(-1);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_addr  = $urandom;
    bus.icb_cmd_wdata = $urandom;
    check("cmd_ready_busy", bus.icb_cmd_ready, 0);
    check("setup_psel", bus.apb_psel, exp_sel);
    check("setup_penable", bus.apb_penable, 0);
    if (hit) begin
      check("setup_paddr", bus.apb_paddr, addr);
      check("setup_pwrite", bus.apb_pwrite, !rd);
      check("setup_pwdata", bus.apb_pwdata, wdata);
      check("setup_pstrb", bus.apb_pstrb, rd ? 4'h0 : wmask);
      check("setup_rsp_valid", bus.icb_rsp_valid, 0);
      drive_noise(-1);
      n_acc = hang ? TO_CYC : waits + 1;
      for (int a = 0; a < n_acc; a++) begin
        @(negedge clk);
        check("access_psel", bus.apb_psel, exp_sel);
        check("access_penable", bus.apb_penable, 1);
        drive_noise(idx);
        bus.apb_pready[idx]          = !hang && (a == waits);
        bus.apb_pslverr[idx]         = slverr;
        bus.apb_prdata[idx*32 +: 32] = prd;
      end
      @(negedge clk);
      drive_noise(-1);
      exp_err   = hang ? 1'b1 : slverr;
      exp_rdata = (hang || !rd) ? 32'h0 : prd;
    end else begin
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
    end
    for (int b = 0; b <= bp; b++) begin
      check("rsp_valid", bus.icb_rsp_valid, 1);
      check("rsp_rdata", bus.icb_rsp_rdata, exp_rdata);
      check("rsp_err", bus.icb_rsp_err, exp_err);
      check("rsp_cmd_ready", bus.icb_cmd_ready, 0);
      check("rsp_psel", bus.apb_psel, 0);
      check("rsp_penable", bus.apb_penable, 0);
      bus.icb_rsp_ready = (b == bp);
      if (b < bp) begin
        @(negedge clk);
        drive_noise(-1);
      end
    end
    @(negedge clk);
    bus.icb_rsp_ready = 1'b0;
    check("post_rsp_valid", bus.icb_rsp_valid, 0);
    check("post_cmd_ready", bus.icb_cmd_ready, 1);
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = BASE | 32'h0000_2008;
    bus.icb_cmd_read  = 1'b1;
    bus.apb_pready    = 4'b0000;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_penable", bus.apb_penable, 1);
    check("rst_pre_psel", bus.apb_psel, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_psel", bus.apb_psel, 0);
    check("rst_async_penable", bus.apb_penable, 0);
    check("rst_async_rsp_valid", bus.icb_rsp_valid, 0);
    check("rst_async_cmd_ready", bus.icb_cmd_ready, 1);
    bus.apb_pready    = 4'b1111;
    bus.icb_rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_stale_rsp", bus.icb_rsp_valid, 0);
      check("rst_cmd_ready", bus.icb_cmd_ready, 1);
      check("rst_psel_idle", bus.apb_psel, 0);
    end
    bus.icb_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_addr  = 32'h0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = 32'h0;
    bus.icb_cmd_wmask = 4'h0;
    bus.icb_rsp_ready = 1'b0;
    bus.apb_prdata    = '0;
    bus.apb_pready    = '0;
    bus.apb_pslverr   = '0;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", bus.icb_cmd_ready, 1);
    check("reset_rsp_valid", bus.icb_rsp_valid, 0);
    check("reset_rdata", bus.icb_rsp_rdata, 0);
    check("reset_err", bus.icb_rsp_err, 0);
    check("reset_psel", bus.apb_psel, 0);
    check("reset_penable", bus.apb_penable, 0);
    check("reset_paddr", bus.apb_paddr, 0);
    check("reset_pwrite", bus.apb_pwrite, 0);
    check("reset_pwdata", bus.apb_pwdata, 0);
    check("reset_pstrb", bus.apb_pstrb, 0);
    rst = 1'b0;

    run_txn(32'h1000_1004, 1'b0, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);
    run_txn(32'h1000_3010, 1'b1, 32'h0, 4'h0, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
    run_txn(32'h2000_0000, 1'b1, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0, 1'b0);
    run_txn(32'h1000_0040, 1'b0, 32'hA5A5_0F0F, 4'h3, 1, 32'h0, 1'b1, 5, 1'b0);
`ifdef APB_TIMEOUT_EN
    run_txn(32'h1000_2000, 1'b1, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 0, 1'b1);
    run_txn(32'h1000_0004, 1'b1, 32'h0, 4'h0, 0, 32'h0BAD_CAFE, 1'b0, 0, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 4));
      if (kind == 0) begin
        a = $urandom;
        if (model_hit(a)) a[31] = ~a[31];
      end else begin
        a = BASE | (32'($urandom_range(0, 3)) << 12) | ($urandom & 32'h0000_0FFC);
      end
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 5)),
              $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    reset_mid_access();
    run_txn(32'h1000_0008, 1'b1, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
